// File: rtl/uart_cmd_pkg.sv
// Package: opcodes, reply bytes, FSM encoding and payload-length lookup
// shared by uart_cmd_controller and its reply serializer.
package uart_cmd_pkg;

    localparam logic [7:0] OP_SET_SIG = 8'h01;
    localparam logic [7:0] OP_SET_ADD = 8'h02;
    localparam logic [7:0] OP_SET_AMP = 8'h03;
    localparam logic [7:0] OP_RD_SIG  = 8'h04;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHK,
        ST_EXEC,
        ST_TX
    } state_t;

    // Unknown opcodes also report 0; op_known() tells them apart from RD_SIG.
    function automatic logic [2:0] op_len(input logic [7:0] opcode);
        case (opcode)
            OP_SET_SIG:             op_len = 3'd1;
            OP_SET_ADD, OP_SET_AMP: op_len = 3'd4;
            default:                op_len = 3'd0;
        endcase
    endfunction

    function automatic logic op_known(input logic [7:0] opcode);
        return opcode inside {OP_SET_SIG, OP_SET_ADD, OP_SET_AMP, OP_RD_SIG};
    endfunction

endpackage

// File: rtl/uart_reply_serializer.sv
// Reply serializer: loads a 1- or 4-byte reply (left-aligned in a 32-bit word)
// and streams it MSB first over a valid/ready byte interface.
module uart_reply_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_count,
    input  logic        ready,
    output logic [7:0]  data,
    output logic        valid,
    output logic        done
);

    logic [31:0] word;
    logic [2:0]  remaining;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            remaining <= '0;
        end else if (load) begin
            word      <= load_word;
            remaining <= load_count;
        end else if (valid && ready) begin
            word      <= {word[23:0], 8'h00};
            remaining <= remaining - 3'd1;
        end
    end

    assign data  = word[31:24];
    assign valid = (remaining != 3'd0);
    assign done  = valid && ready && (remaining == 3'd1);

endmodule

// File: rtl/uart_cmd_controller.sv
// Framed UART command parser updating the waveform parameter registers and replying ACK/NAK/readback.
// Build option: define UART_CMD_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_cmd_controller
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  HEADER            = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES    = 500000,
    parameter logic [7:0]  DEFAULT_SIGNAL    = 8'd0,
    parameter logic [31:0] DEFAULT_ADDER     = 32'd0,
    parameter logic [31:0] DEFAULT_AMPLITUDE = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        from_uart_ready,
    input  logic [7:0]  from_uart_data,
    input  logic        from_uart_error,
    input  logic        from_uart_valid,
    output logic [7:0]  to_uart_data,
    output logic        to_uart_error,
    output logic        to_uart_valid,
    input  logic        to_uart_ready,
    output logic [7:0]  signalNumber,
    output logic [31:0] adder,
    output logic [31:0] amplitude,
    output logic        cfg_update,
    input  logic [31:0] signal
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam state_t ST_AFTER_DATA = ST_EXEC;
`endif

    state_t        state, next_state;
    logic          rx_beat, receiving, timed_out, nak;
    logic [7:0]    opcode_q, chk_acc;
    logic [31:0]   shift_q;
    logic [2:0]    len_left;
    logic          bad_chk;
    logic [TW-1:0] timer;
    logic          tx_load, tx_done;
    logic [31:0]   tx_word;
    logic [2:0]    tx_count;

    assign rx_beat       = from_uart_valid & from_uart_ready;
    assign receiving     = (state == ST_CMD) || (state == ST_PAYLOAD) || (state == ST_CHK);
    assign timed_out     = receiving && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign nak           = !op_known(opcode_q) || bad_chk;
    assign to_uart_error = 1'b0;

    always_comb begin
        // NOTE: next_state is defaulted first so no branch leaves it unassigned (no latch).
        next_state = state;
        case (state)
            ST_IDLE:
                if (rx_beat && !from_uart_error && from_uart_data == HEADER) next_state = ST_CMD;
            ST_CMD:
                if (rx_beat) begin
                    if (from_uart_error)                     next_state = ST_IDLE;
                    else if (!op_known(from_uart_data))      next_state = ST_EXEC;
                    else if (op_len(from_uart_data) == 3'd0) next_state = ST_AFTER_DATA;
                    else                                     next_state = ST_PAYLOAD;
                end else if (timed_out) begin
                    next_state = ST_IDLE;
                end
            ST_PAYLOAD:
                if (rx_beat) begin
                    if (from_uart_error)        next_state = ST_IDLE;
                    else if (len_left == 3'd1)  next_state = ST_AFTER_DATA;
                end else if (timed_out) begin
                    next_state = ST_IDLE;
                end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CHK:
                if (rx_beat)        next_state = from_uart_error ? ST_IDLE : ST_EXEC;
                else if (timed_out) next_state = ST_IDLE;
`endif
            ST_EXEC: next_state = ST_TX;
            ST_TX:   if (tx_done) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_load  = (state == ST_EXEC);
        tx_word  = {ACK_BYTE, 24'h0};
        tx_count = 3'd1;
        if (nak) begin
            tx_word = {NAK_BYTE, 24'h0};
        end else if (opcode_q == OP_RD_SIG) begin
            tx_word  = signal;
            tx_count = 3'd4;
        end
    end

    // Ready is registered from next_state: low throughout reset and from the first EXEC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            from_uart_ready <= 1'b0;
        end else begin
            state           <= next_state;
            from_uart_ready <= next_state inside {ST_IDLE, ST_CMD, ST_PAYLOAD, ST_CHK};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  timer <= '0;
        else if (rx_beat || !receiving || timed_out) timer <= '0;
        else                                         timer <= timer + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q <= '0;
            shift_q  <= '0;
            len_left <= '0;
            chk_acc  <= '0;
            bad_chk  <= 1'b0;
        end else if (rx_beat && !from_uart_error) begin
            case (state)
                ST_CMD: begin
                    opcode_q <= from_uart_data;
                    len_left <= op_len(from_uart_data);
                    chk_acc  <= from_uart_data;
                    bad_chk  <= 1'b0;
                end
                ST_PAYLOAD: begin
                    shift_q  <= {shift_q[23:0], from_uart_data};
                    len_left <= len_left - 3'd1;
                    chk_acc  <= chk_acc ^ from_uart_data;
                end
                ST_CHK:  bad_chk <= (from_uart_data != chk_acc);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signalNumber <= DEFAULT_SIGNAL;
            adder        <= DEFAULT_ADDER;
            amplitude    <= DEFAULT_AMPLITUDE;
            cfg_update   <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            if (state == ST_EXEC && !nak) begin
                case (opcode_q)
                    OP_SET_SIG: begin signalNumber <= shift_q[7:0]; cfg_update <= 1'b1; end
                    OP_SET_ADD: begin adder        <= shift_q;      cfg_update <= 1'b1; end
                    OP_SET_AMP: begin amplitude    <= shift_q;      cfg_update <= 1'b1; end
                    default:    ;
                endcase
            end
        end
    end

    uart_reply_serializer u_reply (
        .clk        (clk),
        .rst_n      (reset),
        .load       (tx_load),
        .load_word  (tx_word),
        .load_count (tx_count),
        .ready      (to_uart_ready),
        .data       (to_uart_data),
        .valid      (to_uart_valid),
        .done       (tx_done)
    );

endmodule
